// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with valid/ready on both sides, fill level,
// programmable almost-full/almost-empty flags and a synchronous flush.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LW-1:0]         level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         count;
    logic                  wr_en;
    logic                  rd_en;

    // Handshake: a transfer happens on each side at the rising clk edge where
    // valid && ready are both high. Data/valid never depend on ready on the
    // output side; in_ready looks through to out_ready so a full FIFO can
    // accept a word in the same cycle its head is consumed.
    assign out_valid = (count != '0);
    assign in_ready  = (count != LW'(DEPTH)) || out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Flush wins over any transfer in the same cycle.
    assign wr_en = in_valid && in_ready && !flush;
    assign rd_en = out_valid && out_ready && !flush;

    assign level        = count;
    assign almost_full  = (count >= LW'(AF_LEVEL));
    assign almost_empty = (count <= LW'(AE_LEVEL));

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the read port sees the pre-edge contents, so a
    // simultaneous read and write to the same slot returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    assert property (@(posedge clk) disable iff (rst) count <= LW'(DEPTH));

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: table of directed vectors on an 8x8 instance plus a
// scoreboarded random-ready run with mid-stream reset on a 5x12 instance.
module tb_fifo_param;

    logic clk;
    logic rst;
    logic rst5;

    // DEPTH=8, DATA_WIDTH=8 instance
    logic       flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, almost_full, almost_empty;
    logic [7:0] out_data;
    logic [3:0] level;

    // DEPTH=5, DATA_WIDTH=12 instance
    logic        flush5, iv5, or5;
    logic [11:0] din5;
    logic        ir5, ov5, af5, ae5;
    logic [11:0] dout5;
    logic [2:0]  lvl5;

    int tests;
    int failed;

    fifo_param u8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    fifo_param #(.DATA_WIDTH(12), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u5 (
        .clk(clk), .rst(rst5), .flush(flush5),
        .in_data(din5), .in_valid(iv5), .in_ready(ir5),
        .out_data(dout5), .out_valid(ov5), .out_ready(or5),
        .level(lvl5), .almost_full(af5), .almost_empty(ae5)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       fl;
        logic       eov;
        logic [7:0] eod;
        int         elvl;
        logic       eir;
    } vec_t;

    vec_t vecs[$];
    logic [11:0] exp_q[$];

    task automatic add(input logic iv, input logic [7:0] din, input logic ordy,
                       input logic fl, input logic eov, input logic [7:0] eod,
                       input int elvl, input logic eir);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eod = eod; v.elvl = elvl; v.eir = eir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Expected values are the outputs seen just before the edge on which the
    // row's inputs are applied.
    task automatic build_table();
        logic [7:0] fill_d [8];
        logic [7:0] drain_d [8];
        logic [7:0] five_d [5];
        fill_d  = '{8'hfe, 8'hed, 8'hdc, 8'hcb, 8'hba, 8'ha9, 8'h98, 8'h87};
        drain_d = '{8'hed, 8'hdc, 8'hcb, 8'hba, 8'ha9, 8'h98, 8'h87, 8'h01};
        five_d  = '{8'h11, 8'h22, 8'h44, 8'h55, 8'h66};
        for (int k = 0; k < 8; k++)
            add(1'b1, fill_d[k], 1'b0, 1'b0, k > 0, (k > 0) ? 8'hfe : 8'h00, k, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hfe, 8, 1'b0);   // full, stalled
        add(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'hfe, 8, 1'b1);   // full read+write
        for (int j = 0; j < 8; j++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, drain_d[j], 8 - j, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        add(1'b1, 8'h54, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1);   // empty, write+ready
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h54, 1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h54, 1, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        for (int k = 0; k < 5; k++)
            add(1'b1, five_d[k], 1'b0, 1'b0, k > 0, (k > 0) ? 8'h11 : 8'h00, k, 1'b1);
        add(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 5, 1'b1);   // flush + write
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        add(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1, 1'b1);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            #2;
            check("out_valid", i, out_valid, vecs[i].eov);
            check("out_data", i, out_data, vecs[i].eod);
            check("level", i, level, vecs[i].elvl);
            check("in_ready", i, in_ready, vecs[i].eir);
            check("almost_full", i, almost_full, vecs[i].elvl >= 6);
            check("almost_empty", i, almost_empty, vecs[i].elvl <= 2);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic run_scoreboard();
        int  writes;
        int  cyc;
        bit  did_rst;
        bit  wr;
        bit  rd;
        logic [11:0] exp_w;
        writes = 0; cyc = 0; did_rst = 0;
        while ((writes < 23 || exp_q.size() > 0) && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (!did_rst && writes == 12) begin
                iv5 = 1'b0; or5 = 1'b0;
                @(negedge clk);
                rst5 = 1'b1;
                #1;
                check("rst5_level", cyc, lvl5, 0);
                check("rst5_out_valid", cyc, ov5, 0);
                check("rst5_in_ready", cyc, ir5, 1);
                @(posedge clk); #1;
                rst5 = 1'b0;
                exp_q.delete();
                did_rst = 1;
                continue;
            end
            iv5  = (writes < 23);
            din5 = 12'($urandom_range(0, 4095));
            or5  = (writes < 23) ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            check("sb_level", cyc, lvl5, exp_q.size());
            check("sb_out_valid", cyc, ov5, exp_q.size() != 0);
            check("sb_in_ready", cyc, ir5, (exp_q.size() != 5) || or5);
            check("sb_almost_full", cyc, af5, exp_q.size() >= 4);
            check("sb_almost_empty", cyc, ae5, exp_q.size() <= 1);
            rd = (exp_q.size() != 0) && or5;
            wr = iv5 && ((exp_q.size() != 5) || or5);
            if (rd) begin
                exp_w = exp_q.pop_front();
                check("sb_out_data", cyc, dout5, exp_w);
            end
            if (wr) begin
                exp_q.push_back(din5);
                writes++;
            end
        end
        tests++;
        if (writes < 23 || exp_q.size() > 0 || !did_rst) begin
            failed++;
            $display("FAIL sb_budget: writes=%0d pending=%0d rst_done=%0d, required 23/0/1",
                     writes, exp_q.size(), did_rst);
        end
        @(posedge clk); #1;
        iv5 = 1'b0; or5 = 1'b0;
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; rst5 = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        flush5 = 1'b0; iv5 = 1'b0; or5 = 1'b0; din5 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 0, out_valid, 0);
        check("rst_in_ready", 0, in_ready, 1);
        check("rst_level", 0, level, 0);
        check("rst_almost_empty", 0, almost_empty, 1);
        check("rst_almost_full", 0, almost_full, 0);
        check("rst_out_data", 0, out_data, 0);
        check("rst5_init_level", 0, lvl5, 0);
        rst = 1'b0; rst5 = 1'b0;

        build_table();
        run_table();
        run_scoreboard();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
